// File: rtl/cpu_ctrl_fsm_pkg.sv
// cpu_ctrl_pkg: shared opcodes, ALU/access encodings, FSM state type and the
// control bundle passed from the decoder to the sequencer top.
package cpu_ctrl_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_ADDI = 3'd3;
  localparam logic [2:0] OP_LD   = 3'd4;
  localparam logic [2:0] OP_ST   = 3'd5;
  localparam logic [2:0] OP_BZ   = 3'd6;
  localparam logic [2:0] OP_SYS  = 3'd7;
  localparam logic [5:0] HALT_IMM = 6'h3F;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;

  localparam logic [2:0] ACC_NORMAL = 3'b000;

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;

  typedef struct packed {
    logic       pc_en;
    logic       mem_to_reg;
    logic       pc_src;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] jump;
    logic [3:0] alu_ctrl;
    logic       mem_req;
    logic       mem_we;
  } ctrl_t;

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// cpu_ctrl_fsm_if: controller <-> datapath / data-memory signals.
//   master: the sequencer (drives IR and controls, mem_req/mem_we)
//   slave : datapath + data memory (drives BranchFlag, overflow, mem_ack)
interface cpu_ctrl_fsm_if;
  logic [8:0] inst;
  logic       pc_en;
  logic       MemToReg;
  logic       PcSrc;
  logic       ALUSrc;
  logic       RegWrite;
  logic [1:0] Jump;
  logic [3:0] ALUControl;
  logic [2:0] AccControl;
  logic       BranchFlag;
  logic       overflow;
  logic       mem_req;
  logic       mem_we;
  logic       mem_ack;

  modport master (
    output inst, pc_en, MemToReg, PcSrc, ALUSrc, RegWrite, Jump, ALUControl,
           AccControl, mem_req, mem_we,
    input  BranchFlag, overflow, mem_ack
  );

  modport slave (
    input  inst, pc_en, MemToReg, PcSrc, ALUSrc, RegWrite, Jump, ALUControl,
           AccControl, mem_req, mem_we,
    output BranchFlag, overflow, mem_ack
  );
endinterface

// File: rtl/cpu_ctrl_fsm_decode.sv
// cpu_ctrl_decode: combinational (state, opcode, BranchFlag) -> control bundle.
//   st, op, is_halt, branch_flag in; ctl out.
// MEM-state completion controls (pc_en/RegWrite/MemToReg) are produced
// unconditionally here and qualified with mem_ack by the top.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t     st,
  input  logic [2:0] op,
  input  logic       is_halt,
  input  logic       branch_flag,
  output ctrl_t      ctl
);

  always_comb begin
    ctl = '0;
    case (st)
      EXEC: begin
        case (op)
          OP_ADD:  begin ctl.alu_ctrl = ALU_ADD; ctl.reg_write = 1'b1; ctl.pc_en = 1'b1; end
          OP_SUB:  begin ctl.alu_ctrl = ALU_SUB; ctl.reg_write = 1'b1; ctl.pc_en = 1'b1; end
          OP_AND:  begin ctl.alu_ctrl = ALU_AND; ctl.reg_write = 1'b1; ctl.pc_en = 1'b1; end
          OP_ADDI: begin
            ctl.alu_ctrl  = ALU_ADD;
            ctl.alu_src   = 1'b1;
            ctl.reg_write = 1'b1;
            ctl.pc_en     = 1'b1;
          end
          OP_BZ:   begin ctl.pc_src = branch_flag; ctl.pc_en = 1'b1; end
          OP_SYS:  begin
            if (!is_halt) begin
              ctl.jump  = 2'b01;
              ctl.pc_en = 1'b1;
            end
          end
          default: ; // LD/ST: PC held until the memory access completes
        endcase
      end
      MEM: begin
        // address comes from rd2: ADD with ALUSrc=0
        ctl.mem_req    = 1'b1;
        ctl.mem_we     = (op == OP_ST);
        ctl.alu_ctrl   = ALU_ADD;
        ctl.pc_en      = 1'b1;
        ctl.reg_write  = (op == OP_LD);
        ctl.mem_to_reg = (op == OP_LD);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle sequencer (IDLE/FETCH/EXEC/MEM/HALT) for the
// 9-bit-instruction datapath.
//   clk, rst (async, active low), start, imem_inst in;
//   bus (cpu_ctrl_fsm_if.master): IR, datapath controls, mem req/ack;
//   busy, done, err (sticky), instr_count (saturating) out.
// Optional build macro CTRL_OVF_TRAP_EN: ADD/SUB/ADDI overflow in EXEC
// suppresses the write, sets err and halts.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [8:0]          imem_inst,
  cpu_ctrl_fsm_if.master      bus,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [CNT_W-1:0]    instr_count
);

  state_t     st, nxt;
  logic [8:0] ir;
  logic [7:0] tcnt;
  logic       err_q;
  logic [2:0] op;
  logic       is_halt, is_mem, trap, tmo, retire;
  ctrl_t      dec, ctl;

  assign op      = ir[8:6];
  assign is_halt = (op == OP_SYS) && (ir[5:0] == HALT_IMM);
  assign is_mem  = (op == OP_LD) || (op == OP_ST);

`ifdef CTRL_OVF_TRAP_EN
  assign trap = (st == EXEC) && bus.overflow &&
                ((op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI));
`else
  logic unused_ovf;
  assign unused_ovf = bus.overflow;
  assign trap       = 1'b0;
`endif

  // tcnt counts completed ack-less MEM cycles; this is the last allowed one
  assign tmo    = (st == MEM) && !bus.mem_ack && (tcnt == 8'(MEM_TIMEOUT - 1));
  assign retire = ((st == EXEC) && !is_mem && !is_halt && !trap) ||
                  ((st == MEM) && bus.mem_ack);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= IDLE;
    else      st <= nxt;
  end

  always_comb begin
    nxt = st;
    case (st)
      IDLE:  if (start) nxt = FETCH;
      FETCH: nxt = EXEC;
      EXEC: begin
        if (trap || is_halt) nxt = HALT;
        else if (is_mem)     nxt = MEM;
        else                 nxt = FETCH;
      end
      MEM: begin
        if (bus.mem_ack) nxt = FETCH;
        else if (tmo)    nxt = HALT;
      end
      HALT:    nxt = HALT;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir          <= '0;
      tcnt        <= '0;
      err_q       <= 1'b0;
      instr_count <= '0;
    end else begin
      if (st == FETCH) ir <= imem_inst;
      tcnt <= ((st == MEM) && (nxt == MEM)) ? tcnt + 8'd1 : 8'd0;
      if (tmo || trap) err_q <= 1'b1;
      if (retire && (instr_count != '1)) instr_count <= instr_count + 1'b1;
    end
  end

  cpu_ctrl_decode u_dec (
    .st          (st),
    .op          (op),
    .is_halt     (is_halt),
    .branch_flag (bus.BranchFlag),
    .ctl         (dec)
  );

  always_comb begin
    ctl = dec;
    if ((st == MEM) && !bus.mem_ack) begin
      ctl.pc_en      = 1'b0;
      ctl.reg_write  = 1'b0;
      ctl.mem_to_reg = 1'b0;
    end
    if (trap) begin
      ctl.pc_en     = 1'b0;
      ctl.reg_write = 1'b0;
    end
  end

  assign bus.inst       = ir;
  assign bus.pc_en      = ctl.pc_en;
  assign bus.MemToReg   = ctl.mem_to_reg;
  assign bus.PcSrc      = ctl.pc_src;
  assign bus.ALUSrc     = ctl.alu_src;
  assign bus.RegWrite   = ctl.reg_write;
  assign bus.Jump       = ctl.jump;
  assign bus.ALUControl = ctl.alu_ctrl;
  assign bus.AccControl = ACC_NORMAL;
  assign bus.mem_req    = ctl.mem_req;
  assign bus.mem_we     = ctl.mem_we;

  assign busy = (st != IDLE) && (st != HALT);
  assign done = (st == HALT);
  assign err  = err_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: directed + randomized instruction stream checked against
// an instruction-level expectation table for cpu_ctrl_fsm.
module tb_cpu_ctrl_fsm;
  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [8:0]  imem_inst;
  logic        busy, done, err;
  logic [15:0] instr_count;
  int          total = 0, bad = 0;
  int          exp_cnt = 0;
  bit          exp_err = 1'b0;

  cpu_ctrl_fsm_if bus ();

  cpu_ctrl_fsm #(.CNT_W(16), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_inst(imem_inst), .bus(bus),
    .busy(busy), .done(done), .err(err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  logic [12:0] ctl_obs;
  assign ctl_obs = {bus.pc_en, bus.MemToReg, bus.PcSrc, bus.ALUSrc, bus.RegWrite,
                    bus.Jump, bus.ALUControl, bus.mem_req, bus.mem_we};

  function automatic logic [12:0] mk(bit pc, bit m2r, bit psrc, bit asrc, bit rw,
                                     logic [1:0] j, logic [3:0] alu, bit req, bit we);
    return {pc, m2r, psrc, asrc, rw, j, alu, req, we};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  // Instruction-level reference: what EXEC should drive for a given word.
  function automatic logic [12:0] exp_exec(logic [8:0] ins, bit bf, bit trapped);
    logic [2:0]  op;
    logic [12:0] e;
    op = ins[8:6];
    case (op)
      3'd0, 3'd1, 3'd2: e = mk(1, 0, 0, 0, 1, 2'b00, {1'b0, op}, 0, 0);
      3'd3:             e = mk(1, 0, 0, 1, 1, 2'b00, 4'd0, 0, 0);
      3'd6:             e = mk(1, 0, bf, 0, 0, 2'b00, 4'd0, 0, 0);
      3'd7:             e = (ins[5:0] == 6'h3F) ? 13'd0 : mk(1, 0, 0, 0, 0, 2'b01, 4'd0, 0, 0);
      default:          e = 13'd0;
    endcase
    if (trapped) begin
      e[12] = 1'b0; // pc_en
      e[8]  = 1'b0; // RegWrite
    end
    return e;
  endfunction

  // Called in a FETCH cycle (posedge+1). ackd: MEM cycle carrying mem_ack, 0 = never.
  task automatic run_inst(input logic [8:0] ins, input bit bf, input bit ovf, input int ackd);
    bit mem, ld, halt, trapped;
    ld      = (ins[8:6] == 3'd4);
    mem     = ld || (ins[8:6] == 3'd5);
    halt    = (ins == 9'o777);
`ifdef CTRL_OVF_TRAP_EN
    trapped = ovf && (ins[8:6] == 3'd0 || ins[8:6] == 3'd1 || ins[8:6] == 3'd3);
`else
    trapped = 1'b0;
`endif
    imem_inst  = ins;
    bus.mem_ack = 1'($urandom);
    bus.BranchFlag = 1'($urandom);
    #1;
    chk("fetch_ctl",  32'(ctl_obs), 32'd0);
    chk("fetch_busy", 32'(busy), 32'd1);
    chk("fetch_cnt",  32'(instr_count), 32'(exp_cnt));
    chk("fetch_err",  32'(err), 32'(exp_err));
    adv();
    imem_inst = 9'($urandom);
    bus.BranchFlag = bf;
    bus.overflow   = ovf;
    bus.mem_ack    = 1'($urandom);
    #1;
    chk("exec_inst", 32'(bus.inst), 32'(ins));
    chk("exec_ctl",  32'(ctl_obs), 32'(exp_exec(ins, bf, trapped)));
    if (!mem && !halt && !trapped) exp_cnt++;
    if (trapped) exp_err = 1'b1;
    adv();
    bus.overflow = 1'b0;
    bus.mem_ack  = 1'b0;
    if (mem) begin
      for (int k = 1; k <= TMO; k++) begin
        bus.mem_ack = (k == ackd);
        #1;
        if (k == ackd)
          chk("mem_ack_ctl", 32'(ctl_obs), 32'(mk(1, ld, 0, 0, ld, 2'b00, 4'd0, 1, !ld)));
        else
          chk("mem_wait_ctl", 32'(ctl_obs), 32'(mk(0, 0, 0, 0, 0, 2'b00, 4'd0, 1, !ld)));
        if (k == ackd) begin
          exp_cnt++;
          adv();
          bus.mem_ack = 1'b0;
          break;
        end
        if (k == TMO) exp_err = 1'b1;
        adv();
      end
    end
  endtask

  task automatic do_start();
    chk("idle_busy", 32'(busy), 32'd0);
    adv();
    start = 1'b1;
    adv();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_ctl", 32'(ctl_obs), 32'd0);
    chk("rst_cnt", 32'(instr_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    adv();
    rst = 1'b1;
    exp_cnt = 0;
    exp_err = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] ins;
    bit         bf, ovf;
    rst = 1'b0; start = 1'b0; imem_inst = '0;
    bus.BranchFlag = 1'b0; bus.overflow = 1'b0; bus.mem_ack = 1'b0;
    #3;
    chk("rst_ctl0",  32'(ctl_obs), 32'd0);
    chk("rst_inst0", 32'(bus.inst), 32'd0);
    chk("rst_acc0",  32'(bus.AccControl), 32'd0);
    chk("rst_busy0", 32'(busy), 32'd0);
    chk("rst_cnt0",  32'(instr_count), 32'd0);
    adv();
    rst = 1'b1;
    do_start();

    run_inst(9'o012, 0, 0, 0);   // ADD r1,r2
    run_inst(9'o412, 0, 0, 3);   // LD, ack on third MEM cycle
    run_inst(9'o607, 1, 0, 0);   // BZ -1, taken
    run_inst(9'o607, 0, 0, 0);   // BZ -1, not taken
    run_inst(9'o740, 0, 0, 0);   // JMP 0x20
    run_inst(9'o312, 0, 0, 0);   // ADDI, no overflow

    for (int i = 0; i < 40; i++) begin
      ins = 9'($urandom);
      if (ins == 9'o777) ins = 9'o740;
      bf = 1'($urandom);
`ifdef CTRL_OVF_TRAP_EN
      ovf = 1'b0;
`else
      ovf = 1'($urandom);
`endif
      run_inst(ins, bf, ovf, $urandom_range(1, 5));
    end

    // HALT is terminal; start afterwards does nothing
    run_inst(9'o777, 0, 0, 0);
    #1;
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_ctl",  32'(ctl_obs), 32'd0);
    start = 1'b1;
    adv();
    start = 1'b0;
    adv(); adv();
    chk("halt_stay", 32'(done), 32'd1);
    chk("halt_cnt",  32'(instr_count), 32'(exp_cnt));

    // ST with no ack: timeout after TMO MEM cycles
    do_reset();
    do_start();
    run_inst(9'o512, 0, 0, 0);
    #1;
    chk("tmo_err",  32'(err), 32'd1);
    chk("tmo_done", 32'(done), 32'd1);
    chk("tmo_req",  32'(bus.mem_req), 32'd0);
    chk("tmo_cnt",  32'(instr_count), 32'(exp_cnt));

    // async reset in the middle of a load
    do_reset();
    do_start();
    imem_inst = 9'o412;
    adv(); adv();
    #1;
    chk("mid_req_before", 32'(bus.mem_req), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_ctl",  32'(ctl_obs), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_inst", 32'(bus.inst), 32'd0);
    adv();
    rst = 1'b1;
    exp_cnt = 0;
    exp_err = 1'b0;

`ifdef CTRL_OVF_TRAP_EN
    do_start();
    run_inst(9'o312, 0, 1, 0);   // ADDI with overflow traps
    #1;
    chk("trap_err",  32'(err), 32'd1);
    chk("trap_done", 32'(done), 32'd1);
    chk("trap_cnt",  32'(instr_count), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
